// File: rtl/noc_link_pkg.sv
// rtl/noc_link_pkg.sv - shared types and helpers for the NoC link pipeline
package noc_link_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } link_state_t;

  localparam int V_MAX      = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;

  // Outstanding-credit counter width for a downstream buffer of depth b.
  function automatic int out_width(input int b);
    return $clog2(b + 1);
  endfunction

  function automatic bit stages_ok(input int s);
    return (s >= STAGES_MIN) && (s <= STAGES_MAX);
  endfunction

  function automatic logic onehot_ok(input logic [V_MAX-1:0] vc);
    return (vc != '0) && ((vc & (vc - V_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/noc_delay_line.sv
// rtl/noc_delay_line.sv - valid-tagged shift register, data zeroed when a stage is empty
module noc_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         any_valid_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= valid_i ? data_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o     = vld_q[DEPTH-1];
  assign data_o      = dat_q[DEPTH-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/noc_link_pipe.sv
// rtl/noc_link_pipe.sv - router-to-router link stage with credit tracking and drain control
module noc_link_pipe import noc_link_pkg::*; #(
  parameter int Fw     = 32,
  parameter int V      = 4,
  parameter int B      = 4,
  parameter int STAGES = 2,
  parameter int CNTw   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            link_en,
  input  logic [Fw-1:0]   flit_in,
  input  logic            flit_in_wr,
  input  logic [V-1:0]    flit_in_vc,
  output logic [V-1:0]    credit_out,
  output logic [Fw-1:0]   flit_out,
  output logic            flit_out_wr,
  output logic [V-1:0]    flit_out_vc,
  input  logic [V-1:0]    credit_in,
  output logic            link_ready,
  output logic            link_idle,
  output logic            err_overflow,
  output logic            err_underflow,
  output logic            err_off_flit,
  output logic [CNTw-1:0] flit_cnt
);

  localparam int OUTw = out_width(B);

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("noc_link_pipe: STAGES must be within 1..8");
  end

  link_state_t     state_q, state_d;
  logic [OUTw-1:0] out_q [V];
  logic [OUTw-1:0] out_d [V];
  logic            ovf_q, ovf_d, udf_q, udf_d, off_q, off_d;
  logic [CNTw-1:0] cnt_q;
  logic            accept, vc_ok, flit_busy, cred_busy, cred_vld, cnt_zero;
  logic [V-1:0]    cred_data;

  assign accept = flit_in_wr && (state_q != OFF);
  assign vc_ok  = onehot_ok(V_MAX'(flit_in_vc));

  noc_delay_line #(.W(Fw + V), .DEPTH(STAGES)) u_flit_pipe (
    .clk         (clk),
    .rst_n       (reset),
    .valid_i     (accept),
    .data_i      ({flit_in, flit_in_vc}),
    .valid_o     (flit_out_wr),
    .data_o      ({flit_out, flit_out_vc}),
    .any_valid_o (flit_busy)
  );

  noc_delay_line #(.W(V), .DEPTH(STAGES)) u_credit_pipe (
    .clk         (clk),
    .rst_n       (reset),
    .valid_i     (|credit_in),
    .data_i      (credit_in),
    .valid_o     (cred_vld),
    .data_o      (cred_data),
    .any_valid_o (cred_busy)
  );

  assign credit_out = cred_data & {V{cred_vld}};

  always_comb begin
    logic inc, dec;
    inc   = 1'b0;
    dec   = 1'b0;
    // A malformed VC is forwarded but treated as a buffer-accounting violation.
    ovf_d = ovf_q | (accept && !vc_ok);
    udf_d = udf_q;
    off_d = off_q | (flit_in_wr && (state_q == OFF));
    for (int v = 0; v < V; v++) begin
      out_d[v] = out_q[v];
      inc      = accept && vc_ok && flit_in_vc[v];
      dec      = credit_in[v];
      if (inc && !dec) begin
        if (out_q[v] == OUTw'(B)) ovf_d = 1'b1;
        else                      out_d[v] = out_q[v] + OUTw'(1);
      end else if (dec && !inc) begin
        if (out_q[v] == '0) udf_d = 1'b1;
        else                out_d[v] = out_q[v] - OUTw'(1);
      end
    end
  end

  always_comb begin
    cnt_zero = 1'b1;
    for (int v = 0; v < V; v++) begin
      if (out_q[v] != '0) cnt_zero = 1'b0;
    end
  end

  assign link_idle = !flit_busy && !cred_busy && cnt_zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (link_en) state_d = ACTIVE;
      ACTIVE:  if (!link_en) state_d = DRAIN;
      DRAIN: begin
        if (link_en)        state_d = ACTIVE;
        else if (link_idle) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OFF;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      off_q   <= 1'b0;
      cnt_q   <= '0;
      for (int v = 0; v < V; v++) out_q[v] <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      off_q   <= off_d;
      cnt_q   <= cnt_q + CNTw'(flit_out_wr);
      out_q   <= out_d;
    end
  end

  assign link_ready    = (state_q == ACTIVE);
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
  assign err_off_flit  = off_q;
  assign flit_cnt      = cnt_q;

endmodule

// File: tb/tb_noc_link_pipe.sv
// tb/tb_noc_link_pipe.sv - self-checking bench for noc_link_pipe against a queue-based reference
module tb_noc_link_pipe;

  localparam int FW = 16;
  localparam int V  = 2;
  localparam int B  = 4;
  localparam int ST = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          link_en;
  logic [FW-1:0] flit_in;
  logic          flit_in_wr;
  logic [V-1:0]  flit_in_vc;
  logic [V-1:0]  credit_out;
  logic [FW-1:0] flit_out;
  logic          flit_out_wr;
  logic [V-1:0]  flit_out_vc;
  logic [V-1:0]  credit_in;
  logic          link_ready, link_idle;
  logic          err_overflow, err_underflow, err_off_flit;
  logic [CW-1:0] flit_cnt;

  noc_link_pipe #(.Fw(FW), .V(V), .B(B), .STAGES(ST), .CNTw(CW)) dut (
    .clk(clk), .reset(reset), .link_en(link_en),
    .flit_in(flit_in), .flit_in_wr(flit_in_wr), .flit_in_vc(flit_in_vc),
    .credit_out(credit_out), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
    .flit_out_vc(flit_out_vc), .credit_in(credit_in), .link_ready(link_ready),
    .link_idle(link_idle), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_off_flit(err_off_flit), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [FW-1:0] d;
    logic [V-1:0]  vc;
  } fitem_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: in-flight items live in queues; outstanding credits are plain ints.
  fitem_t        fq[$];
  logic [V-1:0]  cq[$];
  int            m_st;
  int            m_out [V];
  bit            m_ovf, m_udf, m_off;
  int            m_cnt;
  bit            e_fwr;
  logic [FW-1:0] e_f;
  logic [V-1:0]  e_fvc, e_cr;

  task automatic model_reset();
    fitem_t z;
    z.v = 0; z.d = '0; z.vc = '0;
    fq.delete(); cq.delete();
    for (int i = 0; i < ST - 1; i++) begin fq.push_back(z); cq.push_back('0); end
    m_st = 0; m_ovf = 0; m_udf = 0; m_off = 0; m_cnt = 0;
    for (int v = 0; v < V; v++) m_out[v] = 0;
    e_fwr = 0; e_f = '0; e_fvc = '0; e_cr = '0;
  endtask

  function automatic bit model_idle();
    if (e_fwr || e_cr != '0) return 0;
    foreach (fq[i]) if (fq[i].v) return 0;
    foreach (cq[i]) if (cq[i] != '0) return 0;
    for (int v = 0; v < V; v++) if (m_out[v] != 0) return 0;
    return 1;
  endfunction

  task automatic model_edge(input bit en, input bit wr, input logic [FW-1:0] f,
                            input logic [V-1:0] vc, input logic [V-1:0] cr);
    bit idle, acc, ok, inc, dec;
    fitem_t it;
    idle = model_idle();
    acc  = wr && (m_st != 0);
    ok   = ($countones(vc) == 1);
    if (e_fwr) m_cnt = (m_cnt + 1) % (1 << CW);
    for (int v = 0; v < V; v++) begin
      inc = acc && ok && vc[v];
      dec = cr[v];
      if (inc && !dec) begin
        if (m_out[v] == B) m_ovf = 1; else m_out[v]++;
      end else if (dec && !inc) begin
        if (m_out[v] == 0) m_udf = 1; else m_out[v]--;
      end
    end
    if (acc && !ok) m_ovf = 1;
    if (wr && m_st == 0) m_off = 1;
    it.v = acc; it.d = acc ? f : '0; it.vc = acc ? vc : '0;
    fq.push_back(it);
    it = fq.pop_front();
    e_fwr = it.v; e_f = it.d; e_fvc = it.vc;
    cq.push_back(cr);
    e_cr = cq.pop_front();
    case (m_st)
      0: if (en) m_st = 1;
      1: if (!en) m_st = 2;
      default: if (en) m_st = 1; else if (idle) m_st = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("flit_out_wr", 32'(flit_out_wr), 32'(e_fwr));
    chk("flit_out", 32'(flit_out), 32'(e_f));
    chk("flit_out_vc", 32'(flit_out_vc), 32'(e_fvc));
    chk("credit_out", 32'(credit_out), 32'(e_cr));
    chk("link_ready", 32'(link_ready), 32'(m_st == 1));
    chk("link_idle", 32'(link_idle), 32'(model_idle()));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_udf));
    chk("err_off_flit", 32'(err_off_flit), 32'(m_off));
    chk("flit_cnt", 32'(flit_cnt), 32'(m_cnt));
  endtask

  task automatic step(input bit en, input bit wr, input logic [FW-1:0] f,
                      input logic [V-1:0] vc, input logic [V-1:0] cr);
    link_en = en; flit_in_wr = wr; flit_in = f; flit_in_vc = vc; credit_in = cr;
    @(posedge clk);
    model_edge(en, wr, f, vc, cr);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    logic [V-1:0] rvc, rcr;
    int r;
    bit seg_en;
    reset = 1'b0; link_en = 0; flit_in = '0; flit_in_wr = 0; flit_in_vc = '0; credit_in = '0;
    model_reset();
    #12 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk) reset = 1'b1;

    // Bring-up and the first flit on VC1 followed by one on VC0.
    for (int i = 0; i < 9; i++) step(1, 0, '0, '0, '0);
    step(1, 1, 16'h00A5, 2'b10, '0);
    step(1, 1, 16'h003C, 2'b01, '0);
    step(1, 0, '0, '0, '0);
    chk("a5_payload", 32'(flit_out), 32'h00A5);
    chk("a5_vc", 32'(flit_out_vc), 32'h2);
    for (int i = 0; i < 5; i++) step(1, 0, '0, '0, '0);
    step(1, 0, '0, '0, 2'b11);
    for (int i = 0; i < ST + 1; i++) step(1, 0, '0, '0, '0);
    chk("idle_after_credits", 32'(link_idle), 32'h1);

    // Overflow on VC0, then simultaneous flit+credit at the limit.
    for (int i = 0; i < 4; i++) step(1, 1, 16'(16'h100 + i), 2'b01, '0);
    chk("no_ovf_at_4", 32'(err_overflow), 32'h0);
    step(1, 1, 16'h0104, 2'b01, '0);
    chk("ovf_on_5th", 32'(err_overflow), 32'h1);
    step(1, 1, 16'h0105, 2'b01, 2'b01);
    for (int i = 0; i < 4; i++) step(1, 0, '0, '0, 2'b01);
    for (int i = 0; i < ST + 1; i++) step(1, 0, '0, '0, '0);
    chk("no_udf_after_4_credits", 32'(err_underflow), 32'h0);

    // Drain with flits in the pipe, then return their credits.
    step(1, 1, 16'h0201, 2'b01, '0);
    step(1, 1, 16'h0202, 2'b01, '0);
    step(0, 1, 16'h0203, 2'b01, '0);
    chk("drain_not_ready", 32'(link_ready), 32'h0);
    for (int i = 0; i < ST; i++) step(0, 0, '0, '0, '0);
    step(0, 0, '0, '0, 2'b01);
    step(0, 0, '0, '0, 2'b01);
    step(0, 0, '0, '0, 2'b01);
    for (int i = 0; i < ST + 3; i++) step(0, 0, '0, '0, '0);

    // OFF-state misuse.
    step(0, 1, 16'h0077, 2'b01, '0);
    chk("off_flit_flag", 32'(err_off_flit), 32'h1);
    step(0, 0, '0, '0, 2'b10);
    chk("underflow_flag", 32'(err_underflow), 32'h1);
    for (int i = 0; i < ST + 1; i++) step(0, 0, '0, '0, '0);

    // Randomised segments of enabled and draining operation.
    pulse_reset();
    for (int seg = 0; seg < 12; seg++) begin
      seg_en = (seg % 3) != 2;
      for (int c = 0; c < 30; c++) begin
        r   = $urandom_range(0, 15);
        rvc = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r % 2 == 1) ? 2'b01 : 2'b10;
        rcr = '0;
        for (int v = 0; v < V; v++)
          if ((m_out[v] > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 60) == 0)
            rcr[v] = 1'b1;
        step(seg_en, $urandom_range(0, 1) == 1, 16'($urandom), rvc, rcr);
      end
    end

    // Asynchronous reset with three flits in flight.
    pulse_reset();
    step(1, 0, '0, '0, '0);
    step(1, 1, 16'h0301, 2'b01, '0);
    step(1, 1, 16'h0302, 2'b10, '0);
    step(1, 1, 16'h0303, 2'b01, '0);
    #3 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < ST + 2; i++) step(0, 0, '0, '0, '0);
    chk("no_ghost_flit", 32'(flit_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
